// File: rtl/timer_stats_pkg.sv
// timer_stats_pkg: shared FSM encoding and default widths for timer_stats
package timer_stats_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2, CLR_TMR = 2'd3} state_e;
  localparam int CNT_W_DEF = 32;
  localparam int SUM_W_DEF = 48;
  localparam logic [63:0] MIN_RESET = '1;
endpackage

// File: rtl/timer_stats_if.sv
// timer_stats_if: link between the interval timer and its statistics block
interface timer_stats_if import timer_stats_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  logic stop;
  logic [CNT_W-1:0] timer_value;
  logic timer_clr;
  modport master (output stop, timer_value, input timer_clr);
  modport slave (input stop, timer_value, output timer_clr);
endinterface

// File: rtl/timer_stats_ctrl.sv
// timer_stats_ctrl: stop edge detect, settle delay and capture/clear sequencing
module timer_stats_ctrl import timer_stats_pkg::*; #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic stop,
  output logic capture,
  output logic overrun,
  output logic timer_clr,
  output logic new_sample,
  output logic busy
);
  state_e state_q, state_d;
  logic stop_q, stop_rise;
  logic [3:0] cnt_q, cnt_d;
  logic timer_clr_q, new_sample_q, busy_q;
  always_comb begin
    stop_rise = stop & ~stop_q;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (stop_rise) begin
        state_d = SETTLE;
        cnt_d = 4'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (cnt_q == '0) state_d = CAPTURE; else cnt_d = cnt_q - 1'b1;
      CAPTURE: state_d = CLR_TMR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      stop_q <= 1'b0;
      cnt_q <= '0;
      timer_clr_q <= 1'b0;
      new_sample_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q <= stop;
      cnt_q <= cnt_d;
      timer_clr_q <= state_q == CAPTURE;
      new_sample_q <= state_q == CAPTURE;
      busy_q <= state_d != IDLE;
    end
  assign capture = state_q == CAPTURE;
  assign overrun = stop_rise && state_q != IDLE;
  assign timer_clr = timer_clr_q;
  assign new_sample = new_sample_q;
  assign busy = busy_q;
endmodule

// File: rtl/timer_stats.sv
// timer_stats: captures settled timer intervals into last/min/max/sum/count statistics
// Optional TIMER_STATS_AVG_EN adds a windowed average output avg_val.
module timer_stats import timer_stats_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF,
  parameter int SETTLE_CYCLES = 2
`ifdef TIMER_STATS_AVG_EN
  , parameter int WIN_LOG2 = 4
`endif
) (
  input  logic clk,
  input  logic reset,
  timer_stats_if.slave tif,
  input  logic stats_clr,
  output logic busy,
  output logic new_sample,
  output logic [CNT_W-1:0] last_val,
  output logic [CNT_W-1:0] min_val,
  output logic [CNT_W-1:0] max_val,
  output logic [SUM_W-1:0] sum_val,
  output logic [31:0] n_samples,
  output logic [15:0] n_overrun
`ifdef TIMER_STATS_AVG_EN
  , output logic [CNT_W-1:0] avg_val
`endif
);
  localparam logic [CNT_W-1:0] MIN_RST = CNT_W'(MIN_RESET);
  logic capture, overrun, timer_clr;
  logic [CNT_W-1:0] v;
  logic [SUM_W:0] sum_ext;
  logic [CNT_W-1:0] last_val_q, last_val_d, min_val_q, min_val_d, max_val_q, max_val_d;
  logic [SUM_W-1:0] sum_val_q, sum_val_d;
  logic [31:0] n_samples_q, n_samples_d;
  logic [15:0] n_overrun_q, n_overrun_d;
  timer_stats_ctrl #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_ctrl (
    .clk(clk), .reset(reset), .stop(tif.stop), .capture(capture), .overrun(overrun),
    .timer_clr(timer_clr), .new_sample(new_sample), .busy(busy)
  );
  assign tif.timer_clr = timer_clr;
  assign v = tif.timer_value;
  // stats_clr outranks a coincident capture, so that sample is dropped
  always_comb begin
    sum_ext = {1'b0, sum_val_q} + {{(SUM_W + 1 - CNT_W){1'b0}}, v};
    last_val_d = stats_clr ? '0 : capture ? v : last_val_q;
    min_val_d = stats_clr ? MIN_RST : (capture && v < min_val_q) ? v : min_val_q;
    max_val_d = stats_clr ? '0 : (capture && v > max_val_q) ? v : max_val_q;
    sum_val_d = stats_clr ? '0 : capture ? (sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0]) : sum_val_q;
    n_samples_d = stats_clr ? '0 : (capture && ~&n_samples_q) ? n_samples_q + 1'b1 : n_samples_q;
    n_overrun_d = stats_clr ? '0 : (overrun && ~&n_overrun_q) ? n_overrun_q + 1'b1 : n_overrun_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_val_q <= '0;
      min_val_q <= MIN_RST;
      max_val_q <= '0;
      sum_val_q <= '0;
      n_samples_q <= '0;
      n_overrun_q <= '0;
    end else begin
      last_val_q <= last_val_d;
      min_val_q <= min_val_d;
      max_val_q <= max_val_d;
      sum_val_q <= sum_val_d;
      n_samples_q <= n_samples_d;
      n_overrun_q <= n_overrun_d;
    end
  assign last_val = last_val_q;
  assign min_val = min_val_q;
  assign max_val = max_val_q;
  assign sum_val = sum_val_q;
  assign n_samples = n_samples_q;
  assign n_overrun = n_overrun_q;
`ifdef TIMER_STATS_AVG_EN
  logic [CNT_W+WIN_LOG2-1:0] acc_q, acc_d, acc_sum;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [CNT_W-1:0] avg_val_q, avg_val_d;
  // the accumulator is wide enough for a full window of all-ones samples
  always_comb begin
    acc_sum = acc_q + (CNT_W + WIN_LOG2)'(v);
    win_d = stats_clr ? '0 : capture ? win_q + 1'b1 : win_q;
    acc_d = (stats_clr || (capture && &win_q)) ? '0 : capture ? acc_sum : acc_q;
    avg_val_d = stats_clr ? '0 : (capture && &win_q) ? CNT_W'(acc_sum >> WIN_LOG2) : avg_val_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc_q <= '0;
      win_q <= '0;
      avg_val_q <= '0;
    end else begin
      acc_q <= acc_d;
      win_q <= win_d;
      avg_val_q <= avg_val_d;
    end
  assign avg_val = avg_val_q;
`endif
endmodule

// File: doc/timer_stats.md
Name: timer_stats

Overview:
- Sits directly downstream of the 32-bit clock-cycle interval timer in the link-latency measurement path.
- Monitors the timer's stop strobe and waits for the count to settle, then captures the measured interval.
- Maintains last/min/max/sum/sample-count statistics for register readout.
- Issues a one-cycle clear back to the timer so the next measurement starts from zero.

Parameters:
- CNT_W, 32, width of timer_value and all interval statistics.
- SUM_W, 48, width of the accumulated sum; saturates, never wraps.
- SETTLE_CYCLES, 2, clocks from stop strobe to capture (covers timer's registered start flag plus output register); legal 1..15.
- WIN_LOG2, 4, log2 of averaging window (optional feature only).

Ports:
- clk, input, 1, sole clock, shared with the timer.
- reset, input, 1, asynchronous, active-low reset.
- stop, input, 1, same signal driving the timer's stop input; rising edge starts a capture.
- timer_value, input, CNT_W, timer count output.
- stats_clr, input, 1, synchronous clear of all statistics.
- timer_clr, output, 1, one-cycle active-high pulse to the timer's synchronous reset.
- busy, output, 1, high in any state other than IDLE.
- last_val, output, CNT_W, most recent captured interval.
- min_val, output, CNT_W, minimum captured interval.
- max_val, output, CNT_W, maximum captured interval.
- sum_val, output, SUM_W, saturating sum of captured intervals.
- n_samples, output, 32, number of captures; saturates at all-ones.
- n_overrun, output, 16, stop edges ignored while busy; saturates.
- new_sample, output, 1, one-cycle pulse when the statistics have been updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - last_val, max_val, sum_val, n_samples and n_overrun are 0.
  - min_val is all-ones.
  - timer_clr, busy and new_sample are 0.
  - State is IDLE; the stop edge-detect register is 0.
- Edge detect: stop_q <= stop every cycle; stop_rise = stop & ~stop_q.
- FSM states and transitions:
  - IDLE: on stop_rise, load settle counter with SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement the counter each cycle; when it reaches 0, go to CAPTURE.
  - CAPTURE: sample timer_value into last_val and update statistics in this same cycle.
    - min_val <= min(min_val, v); max_val <= max(max_val, v).
    - sum_val <= sum_val + v, clamped to all-ones on carry out.
    - n_samples++ (saturating).
    - Pulse new_sample=1 the following cycle, together with CLR_TMR.
  - CLR_TMR: timer_clr=1 for exactly one cycle, then return to IDLE.
- Latency: capture occurs SETTLE_CYCLES+1 cycles after the cycle in which the rising edge is sampled.
- Total busy window: SETTLE_CYCLES+2 cycles.
- stop_rise while busy: the edge is ignored and n_overrun++ (saturating); the FSM is not restarted.
- stats_clr:
  - Takes effect next edge: restores the reset values of all statistics and n_overrun.
  - Does not change FSM state.
  - stats_clr in the CAPTURE cycle has priority: the sample is discarded, but new_sample still pulses and timer_clr still issues.
- timer_value of 0 is a legal sample.
- All-ones timer_value is accepted unchanged; no overflow detection on the timer itself.
- Comparisons and the sum are unsigned. Outputs are registered; no combinational input-to-output paths.
- Reset asserted mid-operation returns everything to reset values immediately; no timer_clr is issued.

Optional Feature:
- Macro: TIMER_STATS_AVG_EN.
- When defined:
  - Adds output avg_val [CNT_W-1:0] and a window accumulator of width CNT_W+WIN_LOG2 plus a window counter.
  - Every capture adds v to the accumulator.
  - After 2^WIN_LOG2 captures, avg_val <= accumulator >> WIN_LOG2; the accumulator and window counter reset.
  - avg_val resets to 0 and is cleared by stats_clr.
- When undefined: avg_val port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package timer_stats_pkg holds:
  - FSM state encoding (IDLE=0, SETTLE=1, CAPTURE=2, CLR_TMR=3).
  - Default CNT_W/SUM_W constants.
  - MIN_RESET constant (all-ones).
- One sub-module: timer_stats_ctrl (edge detect, settle counter, FSM, timer_clr/new_sample/overrun generation).
- The statistics datapath stays in the top module.

Test Plan:
- Single capture:
  - Stimulus: reset, drive timer_value=0x64 and pulse stop.
  - Required: capture at cycle 3 after edge; last=min=max=sum=100, n_samples=1.
  - Required: new_sample and timer_clr pulse for one cycle together.
- Three samples, values 50, 200 and 120:
  - Required: min=50, max=200, sum=370, n_samples=3.
- Overrun:
  - Stimulus: second stop edge 1 cycle after the first.
  - Required: n_overrun=1, one capture only, busy high 4 cycles.
- Saturation:
  - Stimulus: preload via repeated captures of 0xFFFFFFFF (SUM_W=33 build).
  - Required: sum_val clamps at all-ones.
- stats_clr coincident with CAPTURE:
  - Required: all stats at reset values, timer_clr still issued.
  - Required: the next capture of 7 gives min=max=7.
- Reset mid-operation:
  - Stimulus: reset low during SETTLE.
  - Required: immediate reset values, no timer_clr.
  - With TIMER_STATS_AVG_EN and WIN_LOG2=2, captures 4,8,12,16 give avg_val=10.
